// File: rtl/if_fetch.sv
// Instruction-fetch stage: reads a 32-bit little-endian instruction as four
// byte reads, presents {inst, pc} to IF/ID and holds the PC register until accepted.
module if_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_flag,
  input  logic              stall_down,
  output logic              stall_req,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic              inst_valid_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [INST_W-1:0] buf_q, buf_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic              valid_q, valid_d;
  logic              mem_req_c;
  logic              stall_c;

  // Places one byte into its little-endian lane of the assembly buffer.
  function automatic logic [INST_W-1:0] merge_byte(input logic [INST_W-1:0] w,
                                                   input logic [1:0]        lane,
                                                   input logic [7:0]        b);
    logic [INST_W-1:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fetch_pc_d = fetch_pc_q;
    buf_d      = buf_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    valid_d    = valid_q;
    mem_req_c  = 1'b0;
    stall_c    = 1'b1;

    case (state_q)
      S_IDLE: begin
        fetch_pc_d = pc_i;
        buf_d      = '0;
        idx_d      = 2'd0;
        state_d    = S_FETCH;
      end
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ack) begin
          buf_d = merge_byte(buf_q, idx_q, mem_data);
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d   = S_DONE;
            inst_d    = buf_d;
            inst_pc_d = fetch_pc_q;
            valid_d   = 1'b1;
          end
        end
      end
      S_DONE: begin
        // The PC register advances on the same edge the word is accepted.
        stall_c = stall_down;
        if (!stall_down) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A flush wins over everything: any byte acked this cycle is dropped.
    if (jump_flag) begin
      state_d   = S_IDLE;
      idx_d     = 2'd0;
      buf_d     = '0;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      valid_d   = 1'b0;
      mem_req_c = 1'b0;
    end

    if (rst) begin
      mem_req_c = 1'b0;
      stall_c   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    fetch_pc_q <= fetch_pc_d;
    buf_q      <= buf_d;
  end

  assign mem_req      = mem_req_c;
  assign mem_addr     = mem_req_c ? (fetch_pc_q + ADDR_W'(idx_q)) : '0;
  assign stall_req    = stall_c;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized traffic, checked each
// cycle against a transaction-level model of the fetch stage and PC register.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        jump_flag;
  logic [31:0] jaddr;
  logic        stall_down;
  logic        stall_req;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  junk;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_fetch #(.ADDR_W(32), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .jump_flag(jump_flag),
    .stall_down(stall_down), .stall_req(stall_req), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o)
  );

  // Memory contents: the test word at 0x100..0x103, hashed bytes elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h10;
      32'h103: return 8'h00;
      default: begin
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ h[7:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  assign mem_data = mem_ack ? mem_byte(mem_addr) : junk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_n = -1 for the latch cycle, 0..3 bytes collected so far, 4 = holding a word.
  int          m_n = -1;
  bit          m_known = 1'b0;
  logic [31:0] m_pc, m_word, m_inst, m_inst_pc;
  logic        m_valid;

  always @(posedge clk) begin
    logic e_stall;
    e_stall = rst ? 1'b0 : ((m_n == 4) ? stall_down : 1'b1);
    if (rst) begin
      m_known   = 1'b1;
      m_n       = -1;
      m_valid   = 1'b0;
      m_inst    = '0;
      m_inst_pc = '0;
    end else if (jump_flag) begin
      m_n     = -1;
      m_valid = 1'b0;
    end else if (m_n < 0) begin
      m_pc   = pc_i;
      m_word = '0;
      m_n    = 0;
    end else if (m_n < 4) begin
      if (mem_ack) begin
        m_word[8*m_n +: 8] = mem_byte(m_pc + 32'(m_n));
        m_n++;
        if (m_n == 4) begin
          m_inst    = m_word;
          m_inst_pc = m_pc;
          m_valid   = 1'b1;
        end
      end
    end else if (!stall_down) begin
      m_valid = 1'b0;
      m_n     = -1;
    end
    // PC register: reset to 0x100, jump target on flush, +4 when not held.
    if (rst) pc_i <= 32'h100;
    else if (jump_flag) pc_i <= jaddr;
    else if (!e_stall) pc_i <= pc_i + 32'd4;
  end

  always @(negedge clk) begin
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_stall;
    if (m_known) begin
      e_req   = !rst && !jump_flag && (m_n >= 0) && (m_n < 4);
      e_addr  = e_req ? (m_pc + 32'(m_n)) : 32'h0;
      e_stall = rst ? 1'b0 : ((m_n == 4) ? stall_down : 1'b1);
      chk("mem_req", mem_req, e_req);
      chk("mem_addr", mem_addr, e_addr);
      chk("stall_req", stall_req, e_stall);
      chk("inst_valid_o", inst_valid_o, m_valid);
      chk("inst_o", inst_o, m_inst);
      chk("inst_pc_o", inst_pc_o, m_inst_pc);
    end
  end

  task automatic go(input logic r, input logic a, input logic sd,
                    input logic jf, input logic [31:0] ja);
    @(posedge clk);
    #1;
    rst        = r;
    mem_ack    = a;
    stall_down = sd;
    jump_flag  = jf;
    jaddr      = ja;
    junk       = 8'($urandom);
  endtask

  // Entered two time units into the IDLE cycle; returns cycles until valid.
  task automatic fetch_run(input logic gap, input logic [31:0] pc, output int lat);
    int n;
    n = 0;
    while (inst_valid_o !== 1'b1 && n < 40) begin
      go(1'b0, gap ? ((n + 1) % 3 == 0) : 1'b1, 1'b1, 1'b0, 32'h0);
      #2;
      n++;
      if (gap && n >= 1 && n <= 3) chk("addr_held_gap", mem_addr, pc);
      if (!gap && n >= 1 && n <= 4) chk("addr_seq", mem_addr, pc + 32'(n - 1));
    end
    lat = n;
  endtask

  initial begin
    int lat;
    rst = 1'b1; mem_ack = 1'b1; stall_down = 1'b0; jump_flag = 1'b0;
    jaddr = '0; junk = '0;

    // Reset held with mem_ack=1.
    repeat (3) begin
      go(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
      #2;
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_valid", inst_valid_o, 1'b0);
    end
    chk("rst_stall_req", stall_req, 1'b0);

    // Back-to-back acks from 0x100, downstream stalled once the word lands.
    go(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    chk("post_rst_stall_req", stall_req, 1'b1);
    fetch_run(1'b0, 32'h100, lat);
    chk("lat_best", lat, 5);
    chk("word_100", inst_o, 32'h0010_0513);
    chk("pc_100", inst_pc_o, 32'h100);

    repeat (4) begin
      go(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      #2;
      chk("hold_valid", inst_valid_o, 1'b1);
      chk("hold_stall_req", stall_req, 1'b1);
      chk("hold_inst", inst_o, 32'h0010_0513);
    end
    go(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    #2;
    chk("accept_stall_req", stall_req, 1'b0);
    go(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    chk("accept_valid_drop", inst_valid_o, 1'b0);
    fetch_run(1'b0, 32'h104, lat);
    chk("pc_104", inst_pc_o, 32'h104);
    chk("word_104", inst_o, word_at(32'h104));

    // Flush in DONE back to 0x100, then refetch with two-cycle ack gaps.
    go(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    #2;
    go(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    #2;
    chk("flush_done_valid", inst_valid_o, 1'b0);
    fetch_run(1'b1, 32'h100, lat);
    chk("lat_gap", lat, 13);
    chk("word_gap", inst_o, 32'h0010_0513);

    // Flush at byte 2 with a coincident ack, target 0x200.
    go(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    go(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    go(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    go(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    go(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    #2;
    chk("flush_fetch_req", mem_req, 1'b0);
    go(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    #2;
    chk("flush_fetch_valid", inst_valid_o, 1'b0);
    fetch_run(1'b0, 32'h200, lat);
    chk("lat_200", lat, 5);
    chk("pc_200", inst_pc_o, 32'h200);
    chk("word_200", inst_o, word_at(32'h200));
    go(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Randomized traffic, including address wrap-around and mid-fetch resets.
    for (int i = 0; i < 3000; i++) begin
      go($urandom_range(0, 199) == 0,
         $urandom_range(0, 9) < 6,
         $urandom_range(0, 9) < 3,
         $urandom_range(0, 29) == 0,
         ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : 32'($urandom));
    end
    go(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
